// File: rtl/divider_pkg.sv
// Shared types and constants for the quotient-to-BCD converter.
// Seven-segment patterns are active-low {g,f,e,d,c,b,a}.
package divider_pkg;

  localparam int unsigned WORD_LENGTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
  end

endmodule

// File: rtl/quotient_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional macro BCD_SEVEN_SEG_EN adds a registered active-low seven-segment output.
module quotient_bcd_converter
  import divider_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = WORD_LENGTH_DEFAULT,
  parameter int unsigned DIGITS      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGTH-1:0]   data_in,
  output logic                     ready,
  output logic                     done,
  output logic [4*DIGITS-1:0]      bcd
`ifdef BCD_SEVEN_SEG_EN
  ,
  output logic [7*DIGITS-1:0]      seg
`endif
);

  localparam int unsigned CW = $clog2(WORD_LENGTH + 1);

  state_t                 r_state;
  logic [CW-1:0]          r_count;
  logic [WORD_LENGTH-1:0] r_shift;
  logic [4*DIGITS-1:0]    r_scratch;
  logic [4*DIGITS-1:0]    w_adj;
  logic [4*DIGITS-1:0]    w_shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit(r_scratch[4*g +: 4]),
      .o_digit(w_adj[4*g +: 4])
    );
  end

  // Scratch after correction, with the next binary MSB shifted in at the bottom.
  always_comb begin
    w_shifted = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_shift[WORD_LENGTH-1]};
  end

`ifdef BCD_SEVEN_SEG_EN
  logic [7*DIGITS-1:0] w_seg_next;

  always_comb begin
    w_seg_next = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_seg_next[7*i +: 7] = seg_encode(w_shifted[4*i +: 4]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_shift   <= '0;
      r_scratch <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      bcd       <= '0;
`ifdef BCD_SEVEN_SEG_EN
      for (int unsigned i = 0; i < DIGITS; i++) begin
        seg[7*i +: 7] <= SEG_0;
      end
`endif
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_shift   <= data_in;
            r_scratch <= '0;
            r_count   <= CW'(WORD_LENGTH);
            ready     <= 1'b0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= w_shifted;
          r_shift   <= r_shift << 1;
          r_count   <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            bcd     <= w_shifted;
`ifdef BCD_SEVEN_SEG_EN
            seg     <= w_seg_next;
`endif
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b1;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quotient_bcd_converter.sv
// Self-checking bench for quotient_bcd_converter: latency-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_quotient_bcd_converter;

  localparam int unsigned W = 16;
  localparam int unsigned D = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   data_in = '0;
  logic           ready;
  logic           done;
  logic [4*D-1:0] bcd;
`ifdef BCD_SEVEN_SEG_EN
  logic [7*D-1:0] seg;
`endif

  quotient_bcd_converter #(.WORD_LENGTH(W), .DIGITS(D)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .data_in(data_in),
    .ready(ready),
    .done(done),
    .bcd(bcd)
`ifdef BCD_SEVEN_SEG_EN
    ,
    .seg(seg)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

`ifdef BCD_SEVEN_SEG_EN
  function automatic logic [7*D-1:0] to_seg(input logic [4*D-1:0] b);
    logic [6:0] tbl [10];
    logic [7*D-1:0] r;
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    r = '0;
    for (int unsigned i = 0; i < D; i++) begin
      r[7*i +: 7] = tbl[b[4*i +: 4]];
    end
    return r;
  endfunction
`endif

  // Reference model: a busy window of W+1 edges after acceptance; result
  // appears W edges after acceptance, done pulses on the edge after that.
  bit             m_busy = 1'b0;
  int             m_age = 0;
  logic [W-1:0]   m_val = '0;
  logic [4*D-1:0] m_bcd = '0;
  bit             m_done = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_bcd  = '0;
      m_done = 1'b0;
    end else if (m_busy) begin
      m_age++;
      m_done = (m_age == int'(W) + 1);
      if (m_age == int'(W)) m_bcd = to_bcd(int'(m_val));
      if (m_age == int'(W) + 1) m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_val  = data_in;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_done", {63'b0, done}, {63'b0, m_done});
      chk("model_ready", {63'b0, ready}, {63'b0, !m_busy});
      chk("model_bcd", 64'(bcd), 64'(m_bcd));
`ifdef BCD_SEVEN_SEG_EN
      chk("model_seg", 64'(seg), 64'(to_seg(m_bcd)));
`endif
    end
  end

  // Call on a negedge; returns at the negedge where done is seen.
  task automatic wait_done(output int t, output bit ok, output int rdy_low);
    ok = 1'b0;
    t = 0;
    rdy_low = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        t = cyc;
        return;
      end
      if (!ready) rdy_low++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start(input logic [W-1:0] v, output int t_acc);
    @(negedge clk);
    start = 1'b1;
    data_in = v;
    @(negedge clk);
    start = 1'b0;
    data_in = '0;
    t_acc = cyc;
  endtask

  task automatic convert(input logic [W-1:0] v, input logic [4*D-1:0] exp, input string nm);
    int t_acc, t_done, rl;
    bit ok;
    pulse_start(v, t_acc);
    wait_done(t_done, ok, rl);
    chk({nm, "_done_seen"}, {63'b0, ok}, 64'd1);
    chk({nm, "_latency"}, 64'(t_done - t_acc), 64'd17);
    chk({nm, "_bcd"}, 64'(bcd), 64'(exp));
  endtask

  initial begin
    int t_acc, t_done, t1, t2, rl;
    bit ok, seen;

    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_ready", {63'b0, ready}, 64'd1);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_bcd", 64'(bcd), 64'd0);
`ifdef BCD_SEVEN_SEG_EN
    chk("reset_seg", 64'(seg), 64'(35'b1000000_1000000_1000000_1000000_1000000));
`endif
    reset = 1'b1;

    // 120/6 = 20, also measure the ready-low window
    pulse_start(16'd20, t_acc);
    wait_done(t_done, ok, rl);
    chk("q20_done_seen", {63'b0, ok}, 64'd1);
    chk("q20_latency", 64'(t_done - t_acc), 64'd17);
    chk("q20_ready_low", 64'(rl), 64'd17);
    chk("q20_bcd", 64'(bcd), 64'h00020);
`ifdef BCD_SEVEN_SEG_EN
    chk("q20_seg_d1", 64'(seg[13:7]), 64'(7'b0100100));
    chk("q20_seg_d0", 64'(seg[6:0]), 64'(7'b1000000));
`endif
    @(negedge clk);
    chk("q20_done_one_cycle", {63'b0, done}, 64'd0);

    convert(16'd65535, 20'h65535, "max");
    convert(16'd0, 20'h00000, "zero");
    convert(16'd4096, 20'h04096, "p4096");
    convert(16'd59999, 20'h59999, "n59999");

    // start during SHIFT must be ignored
    pulse_start(16'd321, t_acc);
    repeat (4) @(negedge clk);
    start = 1'b1;
    data_in = 16'd999;
    @(negedge clk);
    start = 1'b0;
    data_in = '0;
    wait_done(t_done, ok, rl);
    chk("ign_done_seen", {63'b0, ok}, 64'd1);
    chk("ign_latency", 64'(t_done - t_acc), 64'd17);
    chk("ign_bcd", 64'(bcd), 64'h00321);
    repeat (20) @(negedge clk);
    chk("ign_no_second", 64'(bcd), 64'h00321);

    // reset at shift 8 aborts without done
    pulse_start(16'd1234, t_acc);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", {63'b0, seen}, 64'd0);
    chk("abort_bcd", 64'(bcd), 64'd0);
    chk("abort_ready", {63'b0, ready}, 64'd1);
    convert(16'd1234, 20'h01234, "after_abort");

    // start held high: back-to-back conversions
    @(negedge clk);
    start = 1'b1;
    data_in = 16'd7;
    @(negedge clk);
    wait_done(t1, ok, rl);
    chk("b2b_first_seen", {63'b0, ok}, 64'd1);
    chk("b2b_first_bcd", 64'(bcd), 64'h00007);
    data_in = 16'd9;
    @(negedge clk);
    wait_done(t2, ok, rl);
    start = 1'b0;
    data_in = '0;
    chk("b2b_second_seen", {63'b0, ok}, 64'd1);
    chk("b2b_spacing", 64'(t2 - t1), 64'd18);
    chk("b2b_second_bcd", 64'(bcd), 64'h00009);

    repeat (25) @(negedge clk);
    chk("idle_ready_end", {63'b0, ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quotient_bcd_converter.md
QUOTIENT_BCD_CONVERTER -- requirements
Module: quotient_bcd_converter

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 16, giving the width of the binary input; it matches the divider result width.
REQ-002 The block SHALL have parameter DIGITS, default 5, giving the number of BCD output digits; this is enough for 65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request conversion of data_in; it is honoured only while ready=1.
REQ-006 The block SHALL have port data_in, input, WORD_LENGTH bits: unsigned binary value, typically the divider result or remainder.
REQ-007 The block SHALL have port ready, output, 1 bit: high in IDLE, meaning the block can accept start.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking bcd valid.
REQ-009 The block SHALL have port bcd, output, 4*DIGITS bits: packed BCD with digit 0 (units) in bits [3:0].

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and DONE, and nothing else.
REQ-011 In IDLE, if start=1, the block SHALL capture data_in into a shift register, clear the digit scratch register, load the bit counter with WORD_LENGTH, and go to SHIFT on the same edge.
REQ-012 In SHIFT, each cycle, the block SHALL add 3 to every scratch digit >=5, then shift {scratch, shift register} left by 1, and decrement the counter.
REQ-013 When the counter reaches 0 after the final shift, the FSM SHALL go to DONE and load the scratch register into bcd.
REQ-014 In DONE, the block SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-015 Latency SHALL be fixed: done is high in the cycle WORD_LENGTH+1 edges after the edge that sampled start.
REQ-016 bcd SHALL hold its value from DONE until the next DONE; it is not cleared on a new start.
REQ-017 start SHALL be ignored in SHIFT and DONE; there is no queuing, and data_in is sampled only on the accept edge.
REQ-018 start held high continuously SHALL produce back-to-back conversions, one every WORD_LENGTH+2 cycles.
REQ-019 A data_in value of 0 SHALL yield bcd=0 with normal latency.
REQ-020 The maximum value 2^WORD_LENGTH-1 SHALL convert exactly, with no overflow into a nonexistent digit.
REQ-021 No scratch digit SHALL ever exceed 9 at DONE.

Reset
REQ-022 While reset=0 at a clock edge, the block SHALL set FSM=IDLE, bcd=0, done=0, ready=1, and clear the counter, shift register and scratch register.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the next accepted start converts normally.
REQ-024 Reset SHALL have priority over start on the same edge.

Configuration
REQ-025 The macro BCD_SEVEN_SEG_EN SHALL control an optional seven-segment output as follows:
- Defined: add output seg, 7*DIGITS bits, active-low segments {g,f,e,d,c,b,a} per digit, registered, and updated in the same cycle as bcd.
- Reset value of seg: all digits show "0".
- Undefined: the seg port and its logic are absent, and all other behaviour is identical.

Structure
REQ-026 Package divider_pkg SHALL hold:
- the WORD_LENGTH default;
- the FSM state typedef (IDLE, SHIFT, DONE);
- the seven-segment digit-pattern constants.
REQ-027 Sub-module bcd_digit_adjust SHALL be combinational: one 4-bit digit in, digit+3 out if the digit is >=5, otherwise unchanged; it is instantiated DIGITS times.

Verification
REQ-028 Scenario: data_in=20 (120/6), start pulse -> done at accept+17 edges, bcd=20'h00020, ready low for 17 cycles.
REQ-029 Scenario: data_in=65535 -> bcd=20'h65535; data_in=0 -> bcd=20'h00000.
REQ-030 Scenario: a second start with data_in=999 pulsed during SHIFT -> ignored; bcd reflects the first value only.
REQ-031 Scenario: reset=0 for one cycle at shift 8 of a conversion of 1234 -> no done, bcd=0; a later start of 1234 -> bcd=20'h01234.
REQ-032 Scenario: start held high with data_in=7, then 9 -> done pulses exactly 18 cycles apart, bcd 20'h00007 then 20'h00009.
REQ-033 Scenario (BCD_SEVEN_SEG_EN defined): data_in=20 -> seg digit 1 = pattern for "2" (7'b0100100), digit 0 = "0" (7'b1000000).
